// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block.
//   DUTY_W    : width of the duty-cycle percentage (0..100 fits in 7 bits)
//   PCT_SCALE : percentage scale applied to high time before dividing
//   DIV_STEPS : quotient bits produced by the serial divider, one per cycle
//   state_t   : capture FSM states
package pwm_pkg;
  localparam int DUTY_W    = 7;
  localparam int PCT_SCALE = 100;
  localparam int DIV_STEPS = 7;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE
  } state_t;
endpackage

// File: rtl/pwm_duty_div.sv
// Serial restoring divider: quotient = floor(numerator*100 / denominator).
// One quotient bit per cycle, MSB (bit DIV_STEPS-1) first.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : load operands (one cycle); iterations follow on the next cycles
//   numerator   : high time (must be <= denominator so the quotient fits 7 bits)
//   denominator : period, never zero
//   quotient    : result, meaningful only while done is high
//   done        : high during the cycle of the final iteration
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  numerator,
  input  logic [CNT_W-1:0]  denominator,
  output logic [DUTY_W-1:0] quotient,
  output logic              done
);
  // Room for numerator*100 and for denominator shifted by up to 6.
  localparam int RW = CNT_W + DUTY_W;

  logic [RW-1:0]     rem;
  logic [RW-1:0]     den;
  logic [RW-1:0]     trial;
  logic [DUTY_W-1:0] q;
  logic [2:0]        step;
  logic              busy;
  logic              take;

  // Compare against the divisor aligned to the current quotient bit instead
  // of shifting the dividend; the quotient never exceeds 100 so 7 bits cover it.
  assign trial    = den << step;
  assign take     = (rem >= trial);
  assign done     = busy && (step == '0);
  // Bit 0 is decided in the done cycle itself, so fold it in combinationally.
  assign quotient = q | {{(DUTY_W-1){1'b0}}, take & done};

  always_ff @(posedge clk) begin
    if (reset) begin
      rem  <= '0;
      den  <= '0;
      q    <= '0;
      step <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= RW'(numerator) * RW'(PCT_SCALE);
      den  <= RW'(denominator);
      q    <= '0;
      step <= 3'(DIV_STEPS - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (take) rem <= rem - trial;
      q[step] <= take;
      if (step == '0) busy <= 1'b0;
      else            step <= step - 3'd1;
    end
  end
endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input
// and reports the duty cycle in integer percent.
// Optional build macro: PWM_CAPTURE_GLITCH_FILTER_EN -- the internal level only
// follows the synchronized input after it has held a new value for 3 cycles.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   pwm_in     : asynchronous PWM input
//   period     : last measured period in clk cycles (rise to rise)
//   high_time  : cycles high within that period
//   duty_pct   : floor(high_time*100/period), 0..100
//   valid      : one-cycle pulse when period/high_time/duty_pct update
//   stuck      : set when no rise is seen for TIMEOUT cycles, cleared on a rise
//   overrun    : sticky, set when a period closes while the divider is busy
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              valid,
  output logic              stuck,
  output logic              overrun
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t            state, state_next;
  logic              s1, s2, s3;
  logic              level, rise;
  logic [CNT_W-1:0]  per_cnt, hi_cnt;
  logic [CNT_W-1:0]  meas_per, meas_hi;
  logic              start, tmo, done;
  logic [DUTY_W-1:0] quotient;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       lvl;

  // lvl moves only when the last three synced samples agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= '0;
      lvl  <= 1'b0;
      s3   <= 1'b0;
    end else begin
      s1   <= pwm_in;
      s2   <= s1;
      hist <= {hist[0], s2};
      if ({hist, s2} == 3'b111)      lvl <= 1'b1;
      else if ({hist, s2} == 3'b000) lvl <= 1'b0;
      s3   <= lvl;
    end
  end

  assign level = lvl;
  assign rise  = lvl & ~s3;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    tmo        = 1'b0;
    unique case (state)
      IDLE:    if (rise) state_next = MEASURE;
      MEASURE: begin
        if (rise) begin
          start      = 1'b1;
          state_next = DIVIDE;
        end else if (per_cnt >= TMO_CNT) begin
          tmo        = 1'b1;
          state_next = IDLE;
        end
      end
      DIVIDE:  if (done) state_next = MEASURE;
      default: state_next = IDLE;
    endcase
  end

  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .numerator   (hi_cnt),
    .denominator (per_cnt),
    .quotient    (quotient),
    .done        (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt   <= '0;
      hi_cnt    <= '0;
      meas_per  <= '0;
      meas_hi   <= '0;
      period    <= '0;
      high_time <= '0;
      duty_pct  <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid <= 1'b0;
      // The rise cycle itself counts as the first (high) cycle of the period.
      if (rise) begin
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
        stuck   <= 1'b0;
      end else if (state != IDLE) begin
        per_cnt <= sat_inc(per_cnt);
        if (level) hi_cnt <= sat_inc(hi_cnt);
      end
      // A period closing while the divider is busy is lost.
      if (rise && state == DIVIDE) overrun <= 1'b1;
      if (start) begin
        meas_per <= per_cnt;
        meas_hi  <= hi_cnt;
      end
      if (done) begin
        period    <= meas_per;
        high_time <= meas_hi;
        duty_pct  <= (quotient > DUTY_W'(PCT_SCALE)) ? DUTY_W'(PCT_SCALE) : quotient;
        valid     <= 1'b1;
      end
      if (tmo) begin
        period    <= '0;
        high_time <= '0;
        duty_pct  <= level ? DUTY_W'(PCT_SCALE) : '0;
        valid     <= 1'b1;
        stuck     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture. Each phase builds a sample-per-cycle waveform, runs a
// reference model over it (rise positions, period/high counts, duty by plain
// arithmetic) to queue the expected valid events, then drives it. A monitor
// pops and compares on every valid pulse, including the cycle it arrives.
module tb_pwm_capture;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4096;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic [6:0]       duty_pct;
  logic             valid, stuck, overrun;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .duty_pct  (duty_pct),
    .valid     (valid),
    .stuck     (stuck),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_n;
    int per;
    int hi;
    int duty;
    bit stk;
  } exp_t;

  exp_t sbq[$];
  bit   wave[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   phase_no = 0;
  bit   exp_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input bit v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask

  task automatic add_pwm(input int p, input int h, input int reps);
    for (int r = 0; r < reps; r++) begin
      add(1'b1, h);
      add(1'b0, p - h);
    end
  endtask

  function automatic bit xat(input int i);
    if (i < 0 || i >= wave.size()) return 1'b0;
    return wave[i];
  endfunction

  // Reference model. Works in input-sample time: a rise first sampled at
  // index t is acted on 2 cycles later, its result appears 9 cycles later.
  task automatic model(input int base, input int n);
    bit   lv[];
    bit   g;
    bit   r;
    bit   armed;
    int   ref_t, last_close, hi;
    exp_t e;
    lv = new[n];
    g = 1'b0;
    for (int i = 0; i < n; i++) begin
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      if (xat(i-3) && xat(i-2) && xat(i-1))        g = 1'b1;
      else if (!xat(i-3) && !xat(i-2) && !xat(i-1)) g = 1'b0;
      lv[i] = g;
`else
      lv[i] = xat(i);
`endif
    end
    armed = 1'b0;
    ref_t = 0;
    last_close = -100;
    exp_ovr = 1'b0;
    for (int t = 0; t < n; t++) begin
      r = lv[t] && !(t > 0 && lv[t-1]);
      if (armed && !r && (t - ref_t) == TIMEOUT) begin
        e.edge_n = base + t + 2; e.per = 0; e.hi = 0;
        e.duty = lv[t] ? 100 : 0; e.stk = 1'b1;
        if (t + 2 < n) sbq.push_back(e);
        armed = 1'b0;
      end
      if (r) begin
        if (!armed) begin
          armed = 1'b1;
          ref_t = t;
        end else if (t - last_close < 8) begin
          // division of the previous period still in progress
          if (t + 2 <= n - 1) exp_ovr = 1'b1;
          ref_t = t;
        end else begin
          hi = 0;
          for (int j = ref_t; j < t; j++) hi += int'(lv[j]);
          e.edge_n = base + t + 9; e.per = t - ref_t; e.hi = hi;
          e.duty = (hi * 100) / (t - ref_t); e.stk = 1'b0;
          if (t + 9 < n) sbq.push_back(e);
          last_close = t;
          ref_t = t;
        end
      end
    end
  endtask

  // Reset for nrst cycles, check the reset state, then drive the queued wave.
  task automatic run_phase(input int nrst);
    int n;
    int base;
    n = wave.size();
    @(negedge clk);
    if (phase_no > 0) chk("overrun_end", overrun, exp_ovr);
    reset = 1'b1;
    pwm_in = 1'b0;
    repeat (nrst) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_duty", duty_pct, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_overrun", overrun, 0);
    chk("sb_drained", sbq.size(), 0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    base = cyc + 1;
    model(base, n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      pwm_in = wave[i];
    end
    phase_no++;
    wave.delete();
  endtask

  // Monitor: every valid pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid) begin
        if (sbq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_valid: got valid=1, expected none (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("valid_cycle", cyc, e.edge_n);
          chk("period", period, e.per);
          chk("high_time", high_time, e.hi);
          chk("duty_pct", duty_pct, e.duty);
          chk("stuck", stuck, e.stk);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, h;
    // 100/30 repeated; ends 5 cycles after a rise so the next reset lands mid-divide
    add(1'b0, 10);
    add_pwm(100, 30, 4);
    add(1'b1, 5);
    run_phase(3);

    // floor cases and random periods; entered through a 1-cycle reset
    add(1'b0, 7);
    add_pwm(200, 133, 3);
    add_pwm(200, 199, 3);
    for (int k = 0; k < 5; k++) begin
      p = $urandom_range(400, 8);
      h = $urandom_range(p - 1, 1);
      add_pwm(p, h, 1);
    end
    add(1'b1, 3);
    add(1'b0, 20);
    run_phase(1);

    // stuck high, then recovery at 50%
    add(1'b0, 5);
    add(1'b1, 5000);
    add_pwm(100, 50, 3);
    add(1'b1, 3);
    add(1'b0, 20);
    run_phase(2);

    // 5-cycle periods between normal ones cause overrun
    add(1'b0, 5);
    add_pwm(100, 30, 2);
    add_pwm(5, 2, 4);
    add_pwm(100, 30, 2);
    add(1'b1, 3);
    add(1'b0, 20);
    run_phase(2);

    // 2-cycle glitch in a low phase
    add(1'b0, 5);
    add_pwm(100, 30, 1);
    add(1'b1, 30);
    add(1'b0, 30);
    add(1'b1, 2);
    add(1'b0, 38);
    add_pwm(100, 30, 2);
    add(1'b1, 3);
    add(1'b0, 20);
    run_phase(2);

    // final reset: checks overrun of the last phase and a drained scoreboard
    run_phase(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
